// File: rtl/axis_block_pkg.sv
// Shared definitions for the AXI4-Stream block engine: FSM state encoding
// and constant-width helpers used for pointer and length sizing.
package axis_block_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    DRAIN = 3'd2,
    START = 3'd3,
    PROC  = 3'd4,
    SEND  = 3'd5
  } state_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned rem;
    res = 0;
    rem = (value > 0) ? value - 1 : 0;
    while (rem != 0) begin
      res = res + 1;
      rem = rem >> 1;
    end
    return res;
  endfunction

  // Index width for an array of 'depth' entries, never narrower than 1 bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/axis_block_out_sender.sv
// Output side of the block engine: captures OUT_WORDS result words on load_i
// and streams them out one per accepted beat, TLAST on the final word.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   load_i            capture data_i and begin streaming (next cycle TVALID=1)
//   data_i            OUT_WORDS result words, word i at [i*DW +: DW]
//   tready_i          downstream ready
//   tdata_o/tlast_o/tvalid_o  registered stream outputs
//   pkt_count_o       completed output packets, wraps
module axis_block_out_sender
  import axis_block_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OUT_WORDS  = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            load_i,
  input  logic [OUT_WORDS*DATA_WIDTH-1:0] data_i,
  input  logic                            tready_i,
  output logic [DATA_WIDTH-1:0]           tdata_o,
  output logic                            tlast_o,
  output logic                            tvalid_o,
  output logic [CNT_WIDTH-1:0]            pkt_count_o
);

  localparam int unsigned   RD_W    = ptr_width(OUT_WORDS);
  localparam logic [RD_W-1:0] RD_LAST = RD_W'(OUT_WORDS - 1);

  logic [DATA_WIDTH-1:0] buf_q [OUT_WORDS];
  logic [RD_W-1:0]       rd_ptr_q;
  logic [RD_W-1:0]       rd_ptr_d;
  logic [DATA_WIDTH-1:0] tdata_q;
  logic                  tlast_q;
  logic                  tvalid_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  beat_c;

  assign beat_c   = tvalid_q & tready_i;
  assign rd_ptr_d = rd_ptr_q + RD_W'(1);

  // Output buffer and stream registers; TDATA/TLAST only move on an accepted beat.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < OUT_WORDS; i++) buf_q[i] <= '0;
      rd_ptr_q <= '0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
      cnt_q    <= '0;
    end else if (load_i) begin
      for (int i = 0; i < OUT_WORDS; i++) buf_q[i] <= data_i[i*DATA_WIDTH +: DATA_WIDTH];
      rd_ptr_q <= '0;
      tdata_q  <= data_i[DATA_WIDTH-1:0];
      tlast_q  <= (OUT_WORDS == 1);
      tvalid_q <= 1'b1;
    end else if (beat_c) begin
      if (rd_ptr_q == RD_LAST) begin
        tvalid_q <= 1'b0;
        tlast_q  <= 1'b0;
        cnt_q    <= cnt_q + CNT_WIDTH'(1);
      end else begin
        rd_ptr_q <= rd_ptr_d;
        tdata_q  <= buf_q[rd_ptr_d];
        tlast_q  <= (rd_ptr_d == RD_LAST);
      end
    end
  end

  assign tdata_o     = tdata_q;
  assign tlast_o     = tlast_q;
  assign tvalid_o    = tvalid_q;
  assign pkt_count_o = cnt_q;

endmodule

// File: rtl/axis_block_processor.sv
// AXI4-Stream block engine: buffers one IN_WORDS packet, hands it in parallel
// to an external core via proc_start/proc_done, then streams OUT_WORDS results.
// Ports:
//   AXIS_ACLK, AXIS_ARESET        clock, asynchronous active-high reset
//   S_AXIS_*                      input stream (TSTRB ignored)
//   M_AXIS_*                      result stream (TSTRB all ones)
//   proc_start/proc_data_in/proc_len   request to core, data held until proc_done
//   proc_done/proc_data_out            core completion, result captured on done
//   err_short/err_long            one-cycle packet length error pulses
//   pkt_count                     completed output packets
module axis_block_processor
  import axis_block_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IN_WORDS   = 8,
  parameter int unsigned OUT_WORDS  = 8,
  parameter int unsigned PAD_SHORT  = 1,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                              AXIS_ACLK,
  input  logic                              AXIS_ARESET,
  input  logic [DATA_WIDTH-1:0]             S_AXIS_TDATA,
  input  logic [DATA_WIDTH/8-1:0]           S_AXIS_TSTRB,
  input  logic                              S_AXIS_TLAST,
  input  logic                              S_AXIS_TVALID,
  output logic                              S_AXIS_TREADY,
  output logic [DATA_WIDTH-1:0]             M_AXIS_TDATA,
  output logic [DATA_WIDTH/8-1:0]           M_AXIS_TSTRB,
  output logic                              M_AXIS_TLAST,
  output logic                              M_AXIS_TVALID,
  input  logic                              M_AXIS_TREADY,
  output logic                              proc_start,
  output logic [IN_WORDS*DATA_WIDTH-1:0]    proc_data_in,
  output logic [clog2(IN_WORDS+1)-1:0]      proc_len,
  input  logic                              proc_done,
  input  logic [OUT_WORDS*DATA_WIDTH-1:0]   proc_data_out,
  output logic                              err_short,
  output logic                              err_long,
  output logic [CNT_WIDTH-1:0]              pkt_count
);

  localparam int unsigned     PTR_W   = ptr_width(IN_WORDS);
  localparam int unsigned     LEN_W   = clog2(IN_WORDS + 1);
  localparam logic [PTR_W-1:0] WR_LAST = PTR_W'(IN_WORDS - 1);

  state_e                state_q;
  logic [DATA_WIDTH-1:0] in_buf_q [IN_WORDS];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [LEN_W-1:0]      len_q;
  logic                  s_tready_q;
  logic                  proc_start_q;
  logic                  err_short_q;
  logic                  err_long_q;
  logic                  s_beat_c;
  logic                  load_c;
  logic                  send_done_c;
  logic                  unused_tstrb_c;

  assign s_beat_c       = S_AXIS_TVALID & s_tready_q;
  assign load_c         = (state_q == PROC) & proc_done;
  assign send_done_c    = (state_q == SEND) & M_AXIS_TVALID & M_AXIS_TREADY & M_AXIS_TLAST;
  assign unused_tstrb_c = ^S_AXIS_TSTRB;

  // Control FSM, input buffer and error pulses. TREADY is registered, so it is
  // raised/lowered on the transition into/out of RECV and DRAIN.
  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET) begin
      state_q      <= IDLE;
      for (int i = 0; i < IN_WORDS; i++) in_buf_q[i] <= '0;
      wr_ptr_q     <= '0;
      len_q        <= '0;
      s_tready_q   <= 1'b0;
      proc_start_q <= 1'b0;
      err_short_q  <= 1'b0;
      err_long_q   <= 1'b0;
    end else begin
      proc_start_q <= 1'b0;
      err_short_q  <= 1'b0;
      err_long_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          state_q    <= RECV;
          s_tready_q <= 1'b1;
          wr_ptr_q   <= '0;
        end
        RECV: begin
          if (s_beat_c) begin
            in_buf_q[wr_ptr_q] <= S_AXIS_TDATA;
            if (wr_ptr_q == WR_LAST) begin
              len_q <= LEN_W'(IN_WORDS);
              if (S_AXIS_TLAST) begin
                state_q      <= START;
                s_tready_q   <= 1'b0;
                proc_start_q <= 1'b1;
              end else begin
                state_q    <= DRAIN;
                err_long_q <= 1'b1;
              end
            end else if (S_AXIS_TLAST) begin
              err_short_q <= 1'b1;
              if (PAD_SHORT != 0) begin
                // Stale words from an earlier packet must not reach the core.
                for (int i = 0; i < IN_WORDS; i++) begin
                  if (PTR_W'(i) > wr_ptr_q) in_buf_q[i] <= '0;
                end
                len_q        <= LEN_W'(wr_ptr_q) + LEN_W'(1);
                state_q      <= START;
                s_tready_q   <= 1'b0;
                proc_start_q <= 1'b1;
              end else begin
                for (int i = 0; i < IN_WORDS; i++) in_buf_q[i] <= '0;
                state_q    <= IDLE;
                s_tready_q <= 1'b0;
              end
            end else begin
              wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
          end
        end
        DRAIN: begin
          // Over-long packet: swallow beats until TLAST, keep the first IN_WORDS.
          if (s_beat_c && S_AXIS_TLAST) begin
            state_q      <= START;
            s_tready_q   <= 1'b0;
            proc_start_q <= 1'b1;
          end
        end
        START: state_q <= PROC;
        PROC: begin
          if (proc_done) state_q <= SEND;
        end
        SEND: begin
          if (send_done_c) state_q <= IDLE;
        end
        default: begin
          state_q    <= IDLE;
          s_tready_q <= 1'b0;
        end
      endcase
    end
  end

  // Parallel view of the input buffer for the core.
  always_comb begin
    proc_data_in = '0;
    for (int i = 0; i < IN_WORDS; i++) proc_data_in[i*DATA_WIDTH +: DATA_WIDTH] = in_buf_q[i];
  end

  axis_block_out_sender #(
    .DATA_WIDTH (DATA_WIDTH),
    .OUT_WORDS  (OUT_WORDS),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_sender (
    .clk_i       (AXIS_ACLK),
    .rst_i       (AXIS_ARESET),
    .load_i      (load_c),
    .data_i      (proc_data_out),
    .tready_i    (M_AXIS_TREADY),
    .tdata_o     (M_AXIS_TDATA),
    .tlast_o     (M_AXIS_TLAST),
    .tvalid_o    (M_AXIS_TVALID),
    .pkt_count_o (pkt_count)
  );

  assign S_AXIS_TREADY = s_tready_q;
  assign M_AXIS_TSTRB  = '1;
  assign proc_start    = proc_start_q;
  assign proc_len      = len_q;
  assign err_short     = err_short_q;
  assign err_long      = err_long_q;

endmodule

// File: tb/tb_axis_block_processor.sv
// Bench for axis_block_processor: instance 0 pads short packets, instance 1 drops them.
module tb_axis_block_processor;

  localparam int DW  = 32;
  localparam int IN  = 8;
  localparam int OUT = 8;
  localparam int W   = IN * DW;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [DW-1:0] s_tdata [2];
  logic          s_tlast [2];
  logic          s_tvalid[2];
  logic          s_tready[2];
  logic [DW-1:0] m_tdata [2];
  logic [3:0]    m_tstrb [2];
  logic          m_tlast [2];
  logic          m_tvalid[2];
  logic          m_tready[2];
  logic          proc_start[2];
  logic [W-1:0]  proc_data_in[2];
  logic [3:0]    proc_len[2];
  logic          proc_done[2] = '{1'b0, 1'b0};
  logic [W-1:0]  proc_data_out[2] = '{'0, '0};
  logic          err_short[2];
  logic          err_long[2];
  logic [15:0]   pkt_count[2];

  axis_block_processor #(.DATA_WIDTH(DW), .IN_WORDS(IN), .OUT_WORDS(OUT), .PAD_SHORT(1), .CNT_WIDTH(16)) dut0 (
    .AXIS_ACLK(clk), .AXIS_ARESET(rst),
    .S_AXIS_TDATA(s_tdata[0]), .S_AXIS_TSTRB(4'hF), .S_AXIS_TLAST(s_tlast[0]),
    .S_AXIS_TVALID(s_tvalid[0]), .S_AXIS_TREADY(s_tready[0]),
    .M_AXIS_TDATA(m_tdata[0]), .M_AXIS_TSTRB(m_tstrb[0]), .M_AXIS_TLAST(m_tlast[0]),
    .M_AXIS_TVALID(m_tvalid[0]), .M_AXIS_TREADY(m_tready[0]),
    .proc_start(proc_start[0]), .proc_data_in(proc_data_in[0]), .proc_len(proc_len[0]),
    .proc_done(proc_done[0]), .proc_data_out(proc_data_out[0]),
    .err_short(err_short[0]), .err_long(err_long[0]), .pkt_count(pkt_count[0]));

  axis_block_processor #(.DATA_WIDTH(DW), .IN_WORDS(IN), .OUT_WORDS(OUT), .PAD_SHORT(0), .CNT_WIDTH(16)) dut1 (
    .AXIS_ACLK(clk), .AXIS_ARESET(rst),
    .S_AXIS_TDATA(s_tdata[1]), .S_AXIS_TSTRB(4'hF), .S_AXIS_TLAST(s_tlast[1]),
    .S_AXIS_TVALID(s_tvalid[1]), .S_AXIS_TREADY(s_tready[1]),
    .M_AXIS_TDATA(m_tdata[1]), .M_AXIS_TSTRB(m_tstrb[1]), .M_AXIS_TLAST(m_tlast[1]),
    .M_AXIS_TVALID(m_tvalid[1]), .M_AXIS_TREADY(m_tready[1]),
    .proc_start(proc_start[1]), .proc_data_in(proc_data_in[1]), .proc_len(proc_len[1]),
    .proc_done(proc_done[1]), .proc_data_out(proc_data_out[1]),
    .err_short(err_short[1]), .err_long(err_long[1]), .pkt_count(pkt_count[1]));

  // Reference model state (per instance)
  logic [W-1:0]  exp_in[2];
  int            exp_len[2];
  bit            exp_pend[2];
  logic [DW-1:0] exp_out[2][OUT];
  int            out_rem[2], out_idx[2], model_cnt[2];
  int            es_cnt[2], el_cnt[2], es_exp[2], el_exp[2], start_cnt[2];
  logic [W-1:0]  last_in[2];
  int            last_len[2];
  logic [DW-1:0] got_first[2], got_last[2];
  bit            prev_stall[2];
  logic [DW-1:0] prev_data[2];
  logic          prev_last[2];
  int            dcnt[2];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at t=%0t", name, $time);
  endtask

  // Expected core request and result for a packet of n words base, base+1, ...
  task automatic model_pkt(input int k, input int n, input logic [DW-1:0] base);
    exp_len[k] = (n < IN) ? n : IN;
    exp_in[k]  = '0;
    for (int i = 0; i < IN && i < n; i++) exp_in[k][i*DW +: DW] = base + DW'(i);
    for (int i = 0; i < OUT; i++) exp_out[k][i] = exp_in[k][i*DW +: DW] + 32'd1;
    if (n < IN) es_exp[k]++;
    if (n > IN) el_exp[k]++;
    exp_pend[k] = !(n < IN && k == 1);
  endtask

  // Core stand-in: answers each proc_start after LAT cycles with word+1.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        dcnt[k] = 0;
        proc_done[k] = 1'b0;
      end else begin
        proc_done[k] = 1'b0;
        if (proc_start[k]) dcnt[k] = LAT;
        else if (dcnt[k] > 0) begin
          dcnt[k]--;
          if (dcnt[k] == 0) begin
            proc_done[k] = 1'b1;
            for (int i = 0; i < OUT; i++) proc_data_out[k][i*DW +: DW] = exp_out[k][i];
          end
        end
      end
    end
  end

  // Compare process: checks every cycle against the model.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        exp_pend[k] = 0; out_rem[k] = 0; out_idx[k] = 0; model_cnt[k] = 0; prev_stall[k] = 0;
      end else begin
        chk("pkt_count", pkt_count[k], 16'(model_cnt[k]));
        chk("in_out_overlap", s_tready[k] & m_tvalid[k], 0);
        if (err_short[k]) es_cnt[k]++;
        if (err_long[k]) el_cnt[k]++;
        if (proc_start[k]) begin
          start_cnt[k]++;
          chk("proc_start_expected", exp_pend[k], 1);
          chk("proc_len", proc_len[k], exp_len[k]);
          chk("proc_data_in", proc_data_in[k], exp_in[k]);
          chk("start_tready_low", s_tready[k], 0);
          last_in[k] = proc_data_in[k];
          last_len[k] = proc_len[k];
          exp_pend[k] = 0; out_rem[k] = OUT; out_idx[k] = 0;
        end
        if (prev_stall[k]) begin
          chk("stall_tvalid", m_tvalid[k], 1);
          chk("stall_tdata", m_tdata[k], prev_data[k]);
          chk("stall_tlast", m_tlast[k], prev_last[k]);
        end
        if (m_tvalid[k]) begin
          chk("tvalid_expected", out_rem[k] > 0, 1);
          if (m_tready[k] && out_rem[k] > 0) begin
            chk("tdata", m_tdata[k], exp_out[k][out_idx[k]]);
            chk("tlast", m_tlast[k], out_idx[k] == OUT - 1);
            if (out_idx[k] == 0) got_first[k] = m_tdata[k];
            got_last[k] = m_tdata[k];
            out_idx[k]++;
            out_rem[k]--;
            if (out_rem[k] == 0) model_cnt[k]++;
          end
        end
        prev_stall[k] = m_tvalid[k] & ~m_tready[k];
        prev_data[k]  = m_tdata[k];
        prev_last[k]  = m_tlast[k];
      end
    end
  end

  task automatic check_reset();
    for (int k = 0; k < 2; k++) begin
      chk("rst_m_tvalid", m_tvalid[k], 0);
      chk("rst_m_tlast", m_tlast[k], 0);
      chk("rst_m_tdata", m_tdata[k], 0);
      chk("rst_m_tstrb", m_tstrb[k], 4'hF);
      chk("rst_s_tready", s_tready[k], 0);
      chk("rst_proc_start", proc_start[k], 0);
      chk("rst_err_short", err_short[k], 0);
      chk("rst_err_long", err_long[k], 0);
      chk("rst_pkt_count", pkt_count[k], 0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Sends n words (TLAST on the last); caller is at posedge+1.
  task automatic send_pkt(input int k, input int n, input logic [DW-1:0] base);
    int t;
    model_pkt(k, n, base);
    for (int i = 0; i < n; i++) begin
      s_tdata[k]  = base + DW'(i);
      s_tlast[k]  = (i == n - 1);
      s_tvalid[k] = 1'b1;
      t = 0;
      @(negedge clk);
      while (!s_tready[k] && t < 300) begin
        @(negedge clk);
        t++;
      end
      if (t >= 300) fail_timeout("s_tready_wait");
      @(posedge clk);
      #1;
    end
    s_tvalid[k] = 1'b0;
    s_tlast[k]  = 1'b0;
  endtask

  task automatic wait_cnt(input int k, input int target, input bit rnd);
    int t;
    t = 0;
    while (pkt_count[k] != 16'(target) && t < 600) begin
      @(posedge clk);
      #1;
      if (rnd) m_tready[k] = 1'($urandom_range(0, 1));
      t++;
    end
    if (t >= 600) fail_timeout("pkt_count_wait");
    m_tready[k] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    for (int k = 0; k < 2; k++) begin
      s_tdata[k] = '0; s_tlast[k] = 1'b0; s_tvalid[k] = 1'b0; m_tready[k] = 1'b1;
      es_cnt[k] = 0; el_cnt[k] = 0; es_exp[k] = 0; el_exp[k] = 0; start_cnt[k] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    check_reset();
    rst = 1'b0;

    // Full packet 1..8
    send_pkt(0, 8, 32'd1);
    wait_cnt(0, 1, 0);
    chk("t1_proc_len", 32'(last_len[0]), 8);
    chk("t1_proc_data_in", last_in[0], 256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001);
    chk("t1_first_out", got_first[0], 32'd2);
    chk("t1_last_out", got_last[0], 32'd9);

    // Short packet dropped on the non-padding instance, then a normal one
    send_pkt(1, 3, 32'h30);
    repeat (20) @(posedge clk);
    #1;
    chk("t3_no_start", start_cnt[1], 0);
    chk("t3_no_output", pkt_count[1], 0);
    chk("t3_err_short", es_cnt[1], 1);
    send_pkt(1, 8, 32'h40);
    wait_cnt(1, 1, 0);
    chk("t3_one_start", start_cnt[1], 1);
    chk("t3_next_first", got_first[1], 32'h41);
    chk("t3_pkt_count", pkt_count[1], 1);

    // Short packet padded: A,B,C
    send_pkt(0, 3, 32'hA0);
    wait_cnt(0, 2, 0);
    chk("t2_proc_len", 32'(last_len[0]), 3);
    chk("t2_proc_data_in", last_in[0], 256'h000000a2_000000a1_000000a0);
    chk("t2_first_out", got_first[0], 32'hA1);
    chk("t2_last_out", got_last[0], 32'd1);
    chk("t2_err_short", es_cnt[0], 1);

    // Long packet: 11 words, first 8 used
    send_pkt(0, 11, 32'd1);
    wait_cnt(0, 3, 0);
    chk("t4_proc_len", 32'(last_len[0]), 8);
    chk("t4_proc_data_in", last_in[0], 256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001);
    chk("t4_err_long_once", el_cnt[0], 1);

    // Random backpressure
    do_reset();
    send_pkt(0, 8, 32'h100);
    wait_cnt(0, 1, 1);
    chk("t5_pkt_count", pkt_count[0], 1);
    chk("t5_first_out", got_first[0], 32'h101);
    chk("t5_last_out", got_last[0], 32'h108);

    // Reset in the middle of the output phase
    send_pkt(0, 8, 32'h200);
    t = 0;
    while (out_idx[0] < 4 && t < 300) begin
      @(posedge clk);
      t++;
    end
    if (t >= 300) fail_timeout("t6_send_wait");
    #2;
    rst = 1'b1;
    #1;
    chk("t6_tvalid_drop", m_tvalid[0], 0);
    chk("t6_pkt_count", pkt_count[0], 0);
    check_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    send_pkt(0, 8, 32'h300);
    wait_cnt(0, 1, 0);
    chk("t6_clean_count", pkt_count[0], 1);
    chk("t6_clean_first", got_first[0], 32'h301);

    for (int k = 0; k < 2; k++) begin
      chk("err_short_total", es_cnt[k], es_exp[k]);
      chk("err_long_total", el_cnt[k], el_exp[k]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
